// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared definitions for the data-bus arbiter: FSM state codes,
//               default sizing constants and width helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Default sizing for a four-master system with an 8-cycle tenure limit
  localparam int DEF_N_REQ    = 4;
  localparam int DEF_MAX_HOLD = 8;

  // Arbiter FSM encoding
  localparam int STATE_W = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  // Owner index width; a single master still needs a one-bit ID field
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Hold counter width; counter only has to reach MAX_HOLD-1
  function automatic int cnt_width(input int max_hold);
    return (max_hold > 2) ? $clog2(max_hold) : 1;
  endfunction

endpackage : bus_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Searches req starting at
//               last_id+1 (wrapping modulo N_REQ) and returns the first set
//               bit as the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import bus_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  output logic             found,
  output logic [ID_W-1:0]  win_id
);

  // Highest legal master index, used to wrap the search pointer
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

  logic [ID_W-1:0] w_idx;

  // Walk the masters in rotating order after last_id; first requester wins
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    w_idx  = last_id;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = (w_idx == LAST_IDX) ? '0 : w_idx + ID_W'(1);
      if (!found && req[w_idx]) begin
        found  = 1'b1;
        win_id = w_idx;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin owner arbiter for the shared tri-state data bus.
//               Grants one master at a time, limits each tenure to MAX_HOLD
//               cycles and leaves the bus undriven for one cycle between
//               owners so no two tri-state drivers ever overlap.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           done,
  output logic [N_REQ-1:0]           grant,
  output logic                       grant_valid,
  output logic [id_width(N_REQ)-1:0] grant_id,
  output logic                       timeout
);

  localparam int ID_W  = id_width(N_REQ);
  localparam int CNT_W = cnt_width(MAX_HOLD);

  // Counter value of the last cycle a master may keep the bus
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  // Pointer value that makes master 0 the first winner after reset
  localparam logic [ID_W-1:0]  LAST_RST  = ID_W'(N_REQ - 1);

  logic [STATE_W-1:0] r_state;
  logic [N_REQ-1:0]   r_grant;
  logic               r_grant_valid;
  logic [ID_W-1:0]    r_grant_id;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_cnt;
  logic [ID_W-1:0]    r_last_id;

  logic               w_found;
  logic [ID_W-1:0]    w_win_id;
  logic [N_REQ-1:0]   w_win_onehot;
  logic               w_own_done;
  logic               w_own_req;
  logic               w_at_limit;
  logic               w_release;

  // One picker serves both arbitration points: from idle and after a turn
  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req     (req),
    .last_id (r_last_id),
    .found   (w_found),
    .win_id  (w_win_id)
  );

  // Decode the winning index into the one-hot bus-enable pattern
  always_comb begin
    w_win_onehot           = '0;
    w_win_onehot[w_win_id] = 1'b1;
  end

  // Masking with the one-hot grant restricts done/req to the current owner
  assign w_own_done = |(done & r_grant);
  assign w_own_req  = |(req & r_grant);
  assign w_at_limit = (r_cnt == HOLD_LAST);
  assign w_release  = w_own_done | ~w_own_req | w_at_limit;

  // Arbiter FSM with grant, owner ID, hold counter and timeout registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_timeout     <= 1'b0;
      r_cnt         <= '0;
      r_last_id     <= LAST_RST;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE, ST_TURN: begin
          r_cnt <= '0;
          if (w_found) begin
            r_state       <= ST_GRANT;
            r_grant       <= w_win_onehot;
            r_grant_valid <= 1'b1;
            r_grant_id    <= w_win_id;
          end else begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state       <= ST_TURN;
            r_last_id     <= r_grant_id;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_cnt         <= '0;
            // Only a limit-forced release counts as a timeout
            r_timeout     <= w_at_limit & ~w_own_done & w_own_req;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
          r_grant_id    <= '0;
          r_cnt         <= '0;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
  assign timeout     = r_timeout;

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Directed self-checking bench for bus_arbiter (N_REQ=4,
//               MAX_HOLD=8) followed by a random-done fairness run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  localparam int N        = 4;
  localparam int HOLD     = 8;
  localparam int WAIT_MAX = (N - 1) * (HOLD + 1);

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       timeout;

  int n_checks;
  int n_fail;

  bus_arbiter #(
    .N_REQ    (N),
    .MAX_HOLD (HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                           input logic et);
    check({tag, ".grant"},       32'(grant),       32'(eg));
    check({tag, ".grant_valid"}, 32'(grant_valid), 32'(|eg));
    check({tag, ".grant_id"},    32'(grant_id),    32'(eid));
    check({tag, ".timeout"},     32'(timeout),     32'(et));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  int         order [5] = '{0, 1, 2, 3, 0};
  int         wt_cnt [4];
  logic [3:0] eg;
  logic [3:0] prev_g;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    req      = 4'b0000;
    done     = 4'b0000;

    // Reset state
    tick();
    tick();
    check_out("reset", 4'b0000, 2'd0, 1'b0);

    // Round robin with every master releasing on its second grant cycle
    rst = 1'b0;
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      eg = 4'(1 << order[k]);
      check_out("rr_c1", eg, 2'(order[k]), 1'b0);
      tick();
      check_out("rr_c2", eg, 2'(order[k]), 1'b0);
      done = eg;
      tick();
      done = 4'b0000;
      check_out("rr_dead", 4'b0000, 2'd0, 1'b0);
      if (k == 4) req = 4'b0100;
      tick();
    end

    // Lone requester held without done: forced release after MAX_HOLD
    for (int c = 0; c < HOLD; c++) begin
      check_out("hold", 4'b0100, 2'd2, 1'b0);
      tick();
    end
    check_out("timeout", 4'b0000, 2'd0, 1'b1);
    tick();
    check_out("regrant2", 4'b0100, 2'd2, 1'b0);

    // Owner drops req mid-tenure; next requester follows a dead cycle
    req = 4'b0010;
    tick();
    check_out("drop2", 4'b0000, 2'd0, 1'b0);
    tick();
    check_out("own1", 4'b0010, 2'd1, 1'b0);
    req = 4'b1010;
    tick();
    check_out("own1_c2", 4'b0010, 2'd1, 1'b0);
    req = 4'b1000;
    tick();
    check_out("drop1", 4'b0000, 2'd0, 1'b0);
    tick();
    check_out("own3", 4'b1000, 2'd3, 1'b0);

    // Non-owner done ignored; owner done on the limit cycle is a normal release
    req = 4'b0001;
    tick();
    check_out("dead3", 4'b0000, 2'd0, 1'b0);
    tick();
    check_out("own0_c0", 4'b0001, 2'd0, 1'b0);
    done = 4'b0100;
    for (int c = 1; c < HOLD - 1; c++) begin
      tick();
      check_out("ign_done2", 4'b0001, 2'd0, 1'b0);
    end
    tick();
    check_out("own0_c7", 4'b0001, 2'd0, 1'b0);
    done = 4'b0001;
    tick();
    done = 4'b0000;
    check_out("done_limit", 4'b0000, 2'd0, 1'b0);

    // Reset in the middle of master 3's tenure
    req = 4'b1001;
    tick();
    check_out("own3b", 4'b1000, 2'd3, 1'b0);
    tick();
    check_out("own3b_c2", 4'b1000, 2'd3, 1'b0);
    rst = 1'b1;
    tick();
    check_out("rst_mid", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    tick();
    check_out("post_rst", 4'b0001, 2'd0, 1'b0);

    // All masters requesting with random done strobes
    prev_g = grant;
    for (int i = 0; i < 4; i++) wt_cnt[i] = 0;
    req = 4'b1111;
    for (int cyc = 0; cyc < 200; cyc++) begin
      done = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      tick();
      check("onehot", 32'((grant & (grant - 4'd1)) == 4'd0), 32'd1);
      check("handover", 32'((prev_g != 4'd0) && (grant != 4'd0) && (grant != prev_g)), 32'd0);
      for (int i = 0; i < 4; i++) begin
        if (grant[i]) wt_cnt[i] = 0;
        else if (!prev_g[i]) wt_cnt[i]++;
        check("wait_bound", 32'(wt_cnt[i] <= WAIT_MAX), 32'd1);
      end
      prev_g = grant;
    end
    done = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bus_arbiter
`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the CPU's single tri-state data bus among up to `N_REQ` bus masters (sequencing controller, I/O port, debug loader, …). It grants exactly one master at a time and bounds each tenure with a hold limit. It inserts one dead cycle between owners so no two tri-state drivers ever overlap. It sits between the masters' request logic and the bus-driver enables; its one-hot grant feeds the masters' tri-state buffer controls directly.

## Interface
Parameters:
- `N_REQ`, default 4, number of requesting masters (≥1).
- `MAX_HOLD`, default 8, maximum consecutive cycles one master may hold the bus (≥2).

Ports:
- `clk`  input  1  single system clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  N_REQ  per-master bus request; level, held until served.
- `done`  input  N_REQ  per-master release strobe; only the bit of the current owner is honoured.
- `grant`  output  N_REQ  one-hot bus ownership (all-zero when the bus is free); registered.
- `grant_valid`  output  1  OR of `grant`; registered.
- `grant_id`  output  clog2(N_REQ) (min 1)  index of the owner; 0 when `grant_valid`=0.
- `timeout`  output  1  one-cycle pulse when a tenure was force-ended by `MAX_HOLD`.

## Operation
- States: `ST_IDLE`, `ST_GRANT`, `ST_TURN`.
- Reset: state=`ST_IDLE`, `grant`=0, `grant_valid`=0, `grant_id`=0, `timeout`=0, hold counter=0, priority pointer `last_id`=N_REQ-1, so master 0 wins first.
- Round-robin pick: search order `last_id+1, last_id+2, …` modulo N_REQ; first set `req` bit wins.
- `ST_IDLE`: if any `req` is set, register the winner into `grant`/`grant_id`, clear the hold counter, and go to `ST_GRANT`. Otherwise stay.
- `ST_GRANT`: the hold counter increments each cycle. The tenure ends on any of these:
  - (a) `done[grant_id]`=1;
  - (b) `req[grant_id]`=0;
  - (c) counter == MAX_HOLD-1.
  - On end: `last_id` ← `grant_id`, `grant` cleared, go to `ST_TURN`.
  - `timeout` is set for the next cycle only when (c) holds and neither (a) nor (b) does.
- `ST_TURN`: bus is undriven (`grant`=0) for exactly one cycle. Then arbitrate as in `ST_IDLE`: a pending winner goes to `ST_GRANT`, otherwise go to `ST_IDLE`.
- `done` bits of non-owners are ignored in all states. `done` in `ST_IDLE`/`ST_TURN` is ignored.
- Hold counter width is clog2(MAX_HOLD). It never wraps because the tenure is terminated at MAX_HOLD-1.
- Invariant: `grant` is always zero or one-hot, and never changes owner without passing through `ST_TURN`.

## Timing
- Grant latency: `req` first sampled high in `ST_IDLE` at edge n → `grant` high after edge n (one cycle).
- Tenure: `grant` stays high up to and including the cycle in which `done` is asserted. It drops at the following edge.
- Handover: release sampled at edge m → `ST_TURN` cycle m..m+1 → next owner granted after edge m+1. Minimum gap is one cycle.
- Forced release: with `req` held and no `done`, `grant` is high for exactly MAX_HOLD cycles, then `timeout`=1 for the single `ST_TURN` cycle.
- Simultaneous `done` and limit: treated as a normal release, `timeout`=0.
- Reset mid-tenure: at the reset edge all outputs return to their reset values and `last_id` returns to N_REQ-1. There is no `ST_TURN` cycle and no `timeout`.
- N_REQ=1: the same master is re-granted after each `ST_TURN` cycle.

## Structure
- Shared package `bus_pkg`: state enum (`ST_IDLE`, `ST_GRANT`, `ST_TURN`) and default width constants.
- One sub-module, `rr_pick`: combinational round-robin picker. Inputs are `req` and `last_id`; outputs are `found` and `win_id`. It is reused for both arbitration points (`ST_IDLE` and `ST_TURN`).
- Top module holds the state register, grant/ID registers, hold counter and `timeout` flop. All flops use synchronous `rst`.

## Test plan
- After reset, `req`=4'b1111 held, each master pulses `done` on its 2nd grant cycle → grant order 0,1,2,3,0. Each grant lasts 2 cycles, each separated by one all-zero cycle.
- `req`=4'b0100 only, held, no `done` → `grant`=4'b0100 for exactly 8 cycles, then `timeout`=1 for one cycle with `grant`=0, then re-granted to 2.
- Owner 1 drops `req[1]` mid-tenure while `req[3]`=1 → `grant` clears next edge, one dead cycle, then `grant`=4'b1000.
- `done[2]` pulsed while master 0 owns the bus → no effect. `done[0]` together with hold-limit cycle → release with `timeout`=0.
- `rst` asserted during master 3's tenure with `req`=4'b1001 → outputs zero at the reset edge. After `rst` is released, master 0 is granted one cycle later.
- Continuous `req`=all-ones for 200 cycles, random `done` → checker confirms `grant` is never multi-hot, there is a dead cycle at every ownership change, and no master waits more than (N_REQ-1)·(MAX_HOLD+1) cycles.
